vault_phase_sequencer: RTL and testbench

Top-level sequencer for the vault puzzle phase units (code lock, switch room, direction, pressure plate, time lock). It enables one phase at a time and issues a one-cycle clear before each phase starts. It watches each phase's done/fail result and applies a per-phase timeout. It counts failed attempts and enforces a lockout window after MAX_RETRIES consecutive failures.

---
 rtl/vault_phase_sequencer_pkg.sv | 11 +
 rtl/vault_phase_sequencer_if.sv | 20 ++
 rtl/vault_phase_sequencer_timer.sv | 15 +
 rtl/vault_phase_sequencer.sv | 74 +++++++
 tb/tb_vault_phase_sequencer.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/vault_phase_sequencer_pkg.sv
// vault_pkg: shared state encoding, failure causes and helpers for the vault sequencer
package vault_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, FAILED, SUCCESS, LOCKOUT} state_t;
  localparam logic [1:0] FC_NONE = 2'd0;
  localparam logic [1:0] FC_PHASE = 2'd1;
  localparam logic [1:0] FC_TIMEOUT = 2'd2;
  localparam logic [1:0] FC_ABORT = 2'd3;
  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return v == 2'd3 ? v : v + 2'd1;
  endfunction
endpackage

// File: rtl/vault_phase_sequencer_if.sv
// vault_phase_sequencer_if: control and status bundle between a controller and the sequencer
interface vault_phase_sequencer_if #(parameter int NUM_PHASES = 5);
  logic start;
  logic abort;
  logic [NUM_PHASES-1:0] phase_done;
  logic [NUM_PHASES-1:0] phase_fail;
  logic [NUM_PHASES-1:0] phase_en;
  logic phase_clr;
  logic [2:0] cur_phase;
  logic busy;
  logic done;
  logic fail;
  logic [1:0] fail_cause;
  logic [1:0] retry_cnt;
  logic locked;
  modport master(output start, abort, phase_done, phase_fail,
                 input phase_en, phase_clr, cur_phase, busy, done, fail, fail_cause, retry_cnt, locked);
  modport slave(input start, abort, phase_done, phase_fail,
                output phase_en, phase_clr, cur_phase, busy, done, fail, fail_cause, retry_cnt, locked);
endinterface

// File: rtl/vault_phase_sequencer_timer.sv
// vault_cycle_timer: up-counter with clear and a terminal-count flag against a runtime limit
module vault_cycle_timer #(parameter int W = 8) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic [W-1:0] term,
  output logic tc
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (!rst || clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign tc = cnt == term;
endmodule

// File: rtl/vault_phase_sequencer.sv
// vault_phase_sequencer: walks the phase units in order with per-phase timeout, retry counting and lockout
module vault_phase_sequencer
  import vault_pkg::*;
#(
  parameter int NUM_PHASES = 5,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MAX_RETRIES = 3,
  parameter int LOCKOUT_CYCLES = 256
) (
  input logic clk,
  input logic rst,
  vault_phase_sequencer_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES > LOCKOUT_CYCLES ? TIMEOUT_CYCLES : LOCKOUT_CYCLES);
  state_t state, state_n;
  logic [2:0] cur;
  logic [1:0] cause, cause_n, retry, retry_inc;
  logic fail_q, tc, pd, pf, last, timed, go, unlock;
  assign pd = bus.phase_done[cur];
  assign pf = bus.phase_fail[cur];
  assign last = cur == 3'(NUM_PHASES - 1);
  assign retry_inc = sat_inc(retry);
  assign go = (state == IDLE || state == SUCCESS) && bus.start;
  assign unlock = state == LOCKOUT && tc;
  vault_cycle_timer #(.W(TW)) u_timer (
    .clk(clk), .rst(rst),
    .clr(state != RUN && state != LOCKOUT),
    .en(state == RUN || state == LOCKOUT),
    .term(state == LOCKOUT ? TW'(LOCKOUT_CYCLES - 1) : TW'(TIMEOUT_CYCLES - 1)),
    .tc(tc)
  );
  assign timed = tc && !pd;
  always_comb begin
    state_n = state;
    cause_n = cause;
    case (state)
      IDLE:    state_n = bus.start ? CLEAR : IDLE;
      CLEAR:   state_n = bus.abort ? FAILED : RUN;
      RUN:     state_n = bus.abort || pf ? FAILED : pd ? (last ? SUCCESS : CLEAR) : tc ? FAILED : RUN;
      FAILED:  state_n = retry_inc == 2'(MAX_RETRIES) ? LOCKOUT : IDLE;
      SUCCESS: state_n = bus.start ? CLEAR : SUCCESS;
      LOCKOUT: state_n = tc ? IDLE : LOCKOUT;
      default: state_n = IDLE;
    endcase
    cause_n = go || unlock ? FC_NONE
            : (state == CLEAR || state == RUN) && bus.abort ? FC_ABORT
            : state == RUN && pf ? FC_PHASE
            : state == RUN && timed ? FC_TIMEOUT
            : cause;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      cause <= FC_NONE;
      cur <= '0;
      retry <= '0;
      fail_q <= 1'b0;
    end else begin
      state <= state_n;
      cause <= cause_n;
      cur <= go ? 3'd0 : state == RUN && state_n == CLEAR ? cur + 3'd1 : cur;
      retry <= state == FAILED ? retry_inc : (state == RUN && state_n == SUCCESS) || unlock ? 2'd0 : retry;
      fail_q <= state == FAILED ? 1'b1 : go || unlock ? 1'b0 : fail_q;
    end
  assign bus.phase_en = state == RUN ? NUM_PHASES'(1) << cur : '0;
  assign bus.phase_clr = state == CLEAR;
  assign bus.cur_phase = cur;
  assign bus.busy = state == CLEAR || state == RUN;
  assign bus.done = state == SUCCESS;
  assign bus.fail = fail_q;
  assign bus.fail_cause = cause;
  assign bus.retry_cnt = retry;
  assign bus.locked = state == LOCKOUT;
endmodule

// File: tb/tb_vault_phase_sequencer.sv
// tb_vault_phase_sequencer: directed scenarios plus random traffic against a cycle-level behavioural model
module tb_vault_phase_sequencer;
  localparam int NP = 5, TO = 8, MR = 3, LC = 16;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0, bad = 0, clr_seen = 0;
  bit chk_on = 1'b0;
  vault_phase_sequencer_if #(.NUM_PHASES(NP)) bus();
  vault_phase_sequencer #(.NUM_PHASES(NP), .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR), .LOCKOUT_CYCLES(LC))
    dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endfunction

  // model: attempt progress kept as flags, phase index, run age and remaining lock cycles
  bit m_clr, m_run, m_fin, m_ok;
  int m_lock, m_age, m_ph, m_fail, m_cause, m_retry;
  always @(posedge clk) begin
    chk_on <= 1'b1;
    if (!rst) begin
      {m_clr, m_run, m_fin, m_ok} = '0;
      m_lock = 0; m_age = 0; m_ph = 0; m_fail = 0; m_cause = 0; m_retry = 0;
    end else if (m_fin) begin
      m_fin = 0;
      m_fail = 1;
      m_retry = m_retry < 3 ? m_retry + 1 : 3;
      if (m_retry == MR) m_lock = LC;
    end else if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) begin m_retry = 0; m_fail = 0; m_cause = 0; end
    end else if (m_clr) begin
      m_clr = 0;
      if (bus.abort) begin m_fin = 1; m_cause = 3; end
      else begin m_run = 1; m_age = 0; end
    end else if (m_run) begin
      m_age++;
      if (bus.abort) begin m_run = 0; m_fin = 1; m_cause = 3; end
      else if (bus.phase_fail[m_ph]) begin m_run = 0; m_fin = 1; m_cause = 1; end
      else if (bus.phase_done[m_ph]) begin
        m_run = 0;
        if (m_ph == NP - 1) begin m_ok = 1; m_retry = 0; end
        else begin m_ph++; m_clr = 1; end
      end else if (m_age == TO) begin m_run = 0; m_fin = 1; m_cause = 2; end
    end else if (bus.start) begin
      m_ok = 0; m_clr = 1; m_ph = 0; m_fail = 0; m_cause = 0;
    end
  end

  always @(negedge clk) if (chk_on) begin
    if (bus.phase_clr) clr_seen++;
    chk("phase_en", int'(bus.phase_en), m_run ? (1 << m_ph) : 0);
    chk("phase_clr", int'(bus.phase_clr), int'(m_clr));
    chk("cur_phase", int'(bus.cur_phase), m_ph);
    chk("busy", int'(bus.busy), int'(m_clr | m_run));
    chk("done", int'(bus.done), int'(m_ok));
    chk("fail", int'(bus.fail), m_fail);
    chk("fail_cause", int'(bus.fail_cause), m_cause);
    chk("retry_cnt", int'(bus.retry_cnt), m_retry);
    chk("locked", int'(bus.locked), int'(m_lock > 0));
  end

  task automatic tick(); @(negedge clk); endtask
  task automatic pulse_start(); bus.start = 1'b1; tick(); bus.start = 1'b0; endtask
  task automatic pulse_done(input int k); bus.phase_done = NP'(1 << k); tick(); bus.phase_done = '0; endtask
  task automatic wait_en(input int k);
    int n = 0;
    while (int'(bus.phase_en) != (1 << k) && n < 40) begin tick(); n++; end
    if (n == 40) chk("wait_en", int'(bus.phase_en), 1 << k);
  endtask

  initial begin
    int n;
    bus.start = 1'b0; bus.abort = 1'b0; bus.phase_done = '0; bus.phase_fail = '0;
    repeat (2) tick();
    rst = 1'b1;
    pulse_start();
    wait_en(0);
    tick();
    rst = 1'b0;
    repeat (2) tick();
    chk("rst_en", int'(bus.phase_en), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_cur", int'(bus.cur_phase), 0);
    rst = 1'b1;
    tick();
    clr_seen = 0;
    pulse_start();
    for (int k = 0; k < NP; k++) begin wait_en(k); repeat (3) tick(); pulse_done(k); end
    chk("happy_done", int'(bus.done), 1);
    chk("happy_retry", int'(bus.retry_cnt), 0);
    chk("happy_clr_pulses", clr_seen, 5);
    pulse_start();
    chk("restart_done", int'(bus.done), 0);
    chk("restart_clr", int'(bus.phase_clr), 1);
    chk("restart_cur", int'(bus.cur_phase), 0);
    wait_en(0); pulse_done(0);
    wait_en(1);
    bus.phase_done = 5'b01000; tick(); bus.phase_done = '0;
    chk("ignore_cur", int'(bus.cur_phase), 1);
    chk("ignore_en", int'(bus.phase_en), 2);
    pulse_done(1);
    wait_en(2);
    bus.phase_done = 5'b00100; bus.phase_fail = 5'b00100; tick();
    bus.phase_done = '0; bus.phase_fail = '0; tick();
    chk("prio_fail", int'(bus.fail), 1);
    chk("prio_cause", int'(bus.fail_cause), 1);
    chk("prio_cur", int'(bus.cur_phase), 2);
    chk("prio_retry", int'(bus.retry_cnt), 1);
    chk("prio_en", int'(bus.phase_en), 0);
    pulse_start();
    wait_en(0);
    n = 0;
    while (bus.phase_en[0] && n < 40) begin tick(); n++; end
    chk("timeout_cycles", n, 8);
    chk("timeout_cause", int'(bus.fail_cause), 2);
    tick();
    pulse_start();
    wait_en(0);
    repeat (7) tick();
    pulse_done(0);
    chk("late_done_clr", int'(bus.phase_clr), 1);
    chk("late_done_cur", int'(bus.cur_phase), 1);
    chk("late_done_cause", int'(bus.fail_cause), 0);
    for (int k = 1; k < NP; k++) begin wait_en(k); pulse_done(k); end
    chk("late_done_ok", int'(bus.done), 1);
    chk("late_done_retry", int'(bus.retry_cnt), 0);
    for (int a = 0; a < 3; a++) begin
      pulse_start();
      wait_en(0);
      repeat (2) tick();
      bus.abort = 1'b1; tick(); bus.abort = 1'b0;
      chk("abort_cause", int'(bus.fail_cause), 3);
      tick();
    end
    n = 0;
    while (bus.locked && n < 40) begin bus.start = (n % 4) == 1; tick(); n++; end
    bus.start = 1'b0;
    chk("lock_cycles", n, LC);
    chk("unlock_retry", int'(bus.retry_cnt), 0);
    chk("unlock_fail", int'(bus.fail), 0);
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom % 150) != 0;
      bus.start = ($urandom % 8) == 0;
      bus.abort = ($urandom % 40) == 0;
      bus.phase_done = ($urandom % 5) == 0 ? NP'($urandom) : '0;
      bus.phase_fail = ($urandom % 25) == 0 ? NP'($urandom) : '0;
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
